// File: rtl/craft_pkg.sv
// craft_pkg: shared definitions for the CRAFT-64 round sequencer.
//   - cipher geometry (NUM_ROUNDS, STATE_W, KEY_W)
//   - round-constant LFSR seeds (RC_A_INIT, RC_B_INIT)
//   - sequencer FSM state encoding
//   - rc_pack(): assembles the 8-bit round constant {a, 1'b0, b}
package craft_pkg;

  localparam int unsigned NUM_ROUNDS = 32;
  localparam int unsigned STATE_W    = 64;
  localparam int unsigned KEY_W      = 128;

  localparam logic [3:0] RC_A_INIT = 4'h1;
  localparam logic [2:0] RC_B_INIT = 3'h1;

  typedef enum logic [1:0] {
    SEQ_IDLE = 2'd0,
    SEQ_RUN  = 2'd1,
    SEQ_DONE = 2'd2
  } seq_state_e;

  function automatic logic [7:0] rc_pack(input logic [3:0] a, input logic [2:0] b);
    return {a, 1'b0, b};
  endfunction

endpackage

// File: rtl/craft_round_sequencer_if.sv
// craft_round_sequencer_if: all non-clock signals of the CRAFT-64 round sequencer.
//   Block input handshake : in_valid, in_ready, plaintext, tweak, key
//   Block output handshake: out_valid, out_ready, ciphertext
//   Key schedule link     : ks_key, ks_tweak, ks_r (to schedule), ks_tk (from schedule)
//   Round datapath link   : rd_din, rd_tk, rd_rc, rd_last (to round), rd_dout (from round)
// Modports:
//   master : the sequencer itself (it owns the round datapath and key schedule inputs)
//   slave  : the surrounding system (bus wrapper, craft_round, craft_key_schedule)
interface craft_round_sequencer_if #(
  parameter int unsigned STATE_W = craft_pkg::STATE_W,
  parameter int unsigned KEY_W   = craft_pkg::KEY_W
);

  logic               in_valid;
  logic               in_ready;
  logic [STATE_W-1:0] plaintext;
  logic [STATE_W-1:0] tweak;
  logic [KEY_W-1:0]   key;

  logic               out_valid;
  logic               out_ready;
  logic [STATE_W-1:0] ciphertext;

  logic [KEY_W-1:0]   ks_key;
  logic [STATE_W-1:0] ks_tweak;
  logic [7:0]         ks_r;
  logic [STATE_W-1:0] ks_tk;

  logic [STATE_W-1:0] rd_din;
  logic [STATE_W-1:0] rd_tk;
  logic [7:0]         rd_rc;
  logic               rd_last;
  logic [STATE_W-1:0] rd_dout;

  modport master (
    input  in_valid, plaintext, tweak, key, out_ready, ks_tk, rd_dout,
    output in_ready, out_valid, ciphertext, ks_key, ks_tweak, ks_r,
           rd_din, rd_tk, rd_rc, rd_last
  );

  modport slave (
    output in_valid, plaintext, tweak, key, out_ready, ks_tk, rd_dout,
    input  in_ready, out_valid, ciphertext, ks_key, ks_tweak, ks_r,
           rd_din, rd_tk, rd_rc, rd_last
  );

endinterface

// File: rtl/craft_rc_lfsr.sv
// craft_rc_lfsr: on-chip CRAFT round-constant generator.
//   clk    in  clock (posedge)
//   rst    in  synchronous active-high reset -> a=RC_A_INIT, b=RC_B_INIT
//   load_i in  reseed both LFSRs (new block accepted)
//   step_i in  advance both LFSRs by one round
//   rc_o   out current round constant {a, 1'b0, b}
// Both LFSRs shift right with new MSB = bit0 ^ bit1 (4-bit and 3-bit).
module craft_rc_lfsr (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic       step_i,
  output logic [7:0] rc_o
);
  import craft_pkg::*;

  logic [3:0] a_q, a_d;
  logic [2:0] b_q, b_d;

  always_comb begin
    a_d = a_q;
    b_d = b_q;
    if (load_i) begin
      a_d = RC_A_INIT;
      b_d = RC_B_INIT;
    end else if (step_i) begin
      a_d = {a_q[0] ^ a_q[1], a_q[3:1]};
      b_d = {b_q[0] ^ b_q[1], b_q[2:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q <= RC_A_INIT;
      b_q <= RC_B_INIT;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
    end
  end

  assign rc_o = rc_pack(a_q, b_q);

endmodule

// File: rtl/craft_round_sequencer.sv
// craft_round_sequencer: iterative controller for CRAFT-64.
//   Accepts {plaintext, tweak, key}, runs NUM_ROUNDS passes through the external
//   combinational craft_round (one per cycle), feeding it the tweakey from the
//   external craft_key_schedule and an on-chip round constant, then returns the
//   ciphertext over a valid/ready handshake.
// Ports:
//   clk  in   single clock, posedge
//   rst  in   synchronous active-high reset
//   bus  craft_round_sequencer_if.master (handshakes, key schedule and round links)
// Build option:
//   CRAFT_SEQ_B2B_ACCEPT_EN - when defined, in_ready is also high in DONE while
//   out_ready is high, so a new block can be loaded on the ciphertext handshake edge.
module craft_round_sequencer #(
  parameter int unsigned NUM_ROUNDS = craft_pkg::NUM_ROUNDS,
  parameter int unsigned STATE_W    = craft_pkg::STATE_W,
  parameter int unsigned KEY_W      = craft_pkg::KEY_W
) (
  input  logic                   clk,
  input  logic                   rst,
  craft_round_sequencer_if.master bus
);
  import craft_pkg::*;

  localparam int unsigned     RND_W    = (NUM_ROUNDS > 1) ? $clog2(NUM_ROUNDS) : 1;
  localparam logic [RND_W-1:0] LAST_RND = RND_W'(NUM_ROUNDS - 1);

  seq_state_e         fsm_q, fsm_d;
  logic [STATE_W-1:0] state_q, state_d;
  logic [STATE_W-1:0] tweak_q, tweak_d;
  logic [KEY_W-1:0]   key_q, key_d;
  logic [RND_W-1:0]   round_q, round_d;
  logic               in_ready;
  logic               accept;
  logic               step;
  logic               last_rnd;
  logic [7:0]         rc;

  assign last_rnd = (round_q == LAST_RND);

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= SEQ_IDLE;
      state_q <= '0;
      tweak_q <= '0;
      key_q   <= '0;
      round_q <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      tweak_q <= tweak_d;
      key_q   <= key_d;
      round_q <= round_d;
    end
  end

  always_comb begin
    fsm_d    = fsm_q;
    state_d  = state_q;
    tweak_d  = tweak_q;
    key_d    = key_q;
    round_d  = round_q;
    in_ready = 1'b0;
    step     = 1'b0;
    accept   = 1'b0;

    case (fsm_q)
      SEQ_IDLE: in_ready = 1'b1;
      SEQ_RUN: begin
        step    = 1'b1;
        state_d = bus.rd_dout;
        if (last_rnd) begin
          round_d = '0;
          fsm_d   = SEQ_DONE;
        end else begin
          round_d = round_q + RND_W'(1);
        end
      end
      SEQ_DONE: begin
        if (bus.out_ready) fsm_d = SEQ_IDLE;
`ifdef CRAFT_SEQ_B2B_ACCEPT_EN
        in_ready = bus.out_ready;
`endif
      end
      default: fsm_d = SEQ_IDLE;
    endcase

    // Accept overrides the DONE->IDLE transition so a back-to-back load goes
    // straight to RUN; in the default build accept can only happen from IDLE.
    accept = in_ready & bus.in_valid;
    if (accept) begin
      state_d = bus.plaintext;
      key_d   = bus.key;
      tweak_d = bus.tweak;
      round_d = '0;
      fsm_d   = SEQ_RUN;
    end
  end

  craft_rc_lfsr u_rc_lfsr (
    .clk    (clk),
    .rst    (rst),
    .load_i (accept),
    .step_i (step),
    .rc_o   (rc)
  );

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = (fsm_q == SEQ_DONE);
  assign bus.ciphertext = state_q;
  assign bus.ks_key     = key_q;
  assign bus.ks_tweak   = tweak_q;
  assign bus.ks_r       = 8'(round_q);
  assign bus.rd_din     = state_q;
  assign bus.rd_tk      = bus.ks_tk;
  assign bus.rd_rc      = rc;
  assign bus.rd_last    = last_rnd;

endmodule

// File: tb/tb_craft_round_sequencer.sv
// tb_craft_round_sequencer: self-checking bench for craft_round_sequencer.
// Behavioural models of the external craft_key_schedule and craft_round drive
// ks_tk / rd_dout; a golden CRAFT-64 encryption is pushed to a scoreboard when
// a block is accepted and compared when the ciphertext handshake happens.
module tb_craft_round_sequencer;
  import craft_pkg::*;

`ifdef CRAFT_SEQ_B2B_ACCEPT_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif

  localparam logic [3:0] SBOX [16] = '{4'hC, 4'hA, 4'hD, 4'h3, 4'hE, 4'hB, 4'hF, 4'h7,
                                       4'h8, 4'h9, 4'h1, 4'h5, 4'h0, 4'h2, 4'h4, 4'h6};
  localparam int PN [16] = '{15, 12, 13, 14, 10, 9, 8, 11, 6, 5, 4, 7, 1, 2, 3, 0};
  localparam int QT [16] = '{12, 10, 15, 5, 14, 8, 9, 2, 11, 3, 7, 4, 6, 0, 1, 13};
  localparam logic [7:0] RC_TAB [16] = '{8'h11, 8'h84, 8'h42, 8'h25, 8'h96, 8'hC7, 8'h63, 8'hB1,
                                         8'h54, 8'hA2, 8'hD5, 8'hE6, 8'hF7, 8'h73, 8'h31, 8'h14};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  craft_round_sequencer_if bus ();

  craft_round_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;
  logic [63:0] sb_q [$];

  // Tweakey schedule: TK0=K0^T, TK1=K1^T, TK2=K0^Q(T), TK3=K1^Q(T); round r uses TK[r mod 4].
  function automatic logic [63:0] tk_model(input logic [127:0] k, input logic [63:0] t,
                                           input logic [7:0] r);
    logic [63:0] qt;
    for (int i = 0; i < 16; i++) qt[63-4*i -: 4] = t[63-4*QT[i] -: 4];
    case (r[1:0])
      2'd0:    return k[127:64] ^ t;
      2'd1:    return k[63:0] ^ t;
      2'd2:    return k[127:64] ^ qt;
      default: return k[63:0] ^ qt;
    endcase
  endfunction

  // One CRAFT round: MixColumn, AddConstant, AddTweakey, then PermuteNibbles and
  // S-box; the final round stops after AddTweakey.
  function automatic logic [63:0] round_model(input logic [63:0] din, input logic [63:0] tk,
                                              input logic [7:0] rc, input logic last);
    logic [3:0] x [16];
    logic [3:0] y [16];
    logic [63:0] o;
    for (int i = 0; i < 16; i++) x[i] = din[63-4*i -: 4];
    for (int j = 0; j < 4; j++) begin
      x[j]   = x[j] ^ x[8+j] ^ x[12+j];
      x[4+j] = x[4+j] ^ x[12+j];
    end
    x[4] = x[4] ^ rc[7:4];
    x[5] = x[5] ^ rc[3:0];
    for (int i = 0; i < 16; i++) x[i] = x[i] ^ tk[63-4*i -: 4];
    if (last) begin
      y = x;
    end else begin
      for (int i = 0; i < 16; i++) y[PN[i]] = x[i];
      for (int i = 0; i < 16; i++) y[i] = SBOX[y[i]];
    end
    for (int i = 0; i < 16; i++) o[63-4*i -: 4] = y[i];
    return o;
  endfunction

  function automatic logic [63:0] golden(input logic [63:0] p, input logic [63:0] t,
                                         input logic [127:0] k);
    logic [3:0]  a;
    logic [2:0]  b;
    logic [63:0] s;
    a = 4'h1;
    b = 3'h1;
    s = p;
    for (int r = 0; r < 32; r++) begin
      s = round_model(s, tk_model(k, t, 8'(r)), {a, 1'b0, b}, r == 31);
      a = {a[0] ^ a[1], a[3:1]};
      b = {b[0] ^ b[1], b[2:1]};
    end
    return s;
  endfunction

  assign bus.ks_tk   = tk_model(bus.ks_key, bus.ks_tweak, bus.ks_r);
  assign bus.rd_dout = round_model(bus.rd_din, bus.rd_tk, bus.rd_rc, bus.rd_last);

  // Present a block from a negedge until accepted; returns at the negedge after the accept edge.
  task automatic accept_block(input logic [63:0] p, input logic [63:0] t,
                              input logic [127:0] k, output bit ok);
    ok = 1'b0;
    bus.plaintext = p;
    bus.tweak     = t;
    bus.key       = k;
    bus.in_valid  = 1'b1;
    for (int n = 0; n < 50 && !ok; n++) begin
      #1;
      if (bus.in_ready) begin
        @(posedge clk);
        sb_q.push_back(golden(p, t, k));
        ok = 1'b1;
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
  endtask

  // Count edges since the accept edge (k0 already elapsed) until out_valid; -1 on timeout.
  task automatic wait_out(input int k0, output int lat);
    lat = -1;
    for (int k = k0; k < 100; k++) begin
      if (bus.out_valid) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.rd_rc !== 8'h11) begin failures++; $display("FAIL reset_rd_rc: got %h expected 11", bus.rd_rc); end
    checks++; if (bus.ks_r !== 8'h00) begin failures++; $display("FAIL reset_ks_r: got %h expected 00", bus.ks_r); end
    checks++; if (bus.rd_din !== 64'h0) begin failures++; $display("FAIL reset_state: got %h expected 0", bus.rd_din); end
    checks++; if (bus.ks_key !== 128'h0) begin failures++; $display("FAIL reset_key: got %h expected 0", bus.ks_key); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin failures++; $display("FAIL idle_after_reset: got in_ready=%b out_valid=%b expected 1/0", bus.in_ready, bus.out_valid); end
  endtask

  task automatic test_single_block();
    bit ok;
    int lat;
    logic [63:0] exp;
    accept_block(64'h5734F006D8D88A3E, 64'h54CD94FFD0670A58,
                 128'h27A6781A43F364BC916708D5FBB5AEFE, ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL single_accept: got %b expected 1", ok); end
    checks++; if (bus.rd_rc !== 8'h11) begin failures++; $display("FAIL single_rc0: got %h expected 11", bus.rd_rc); end
    checks++; if (bus.ks_tk !== 64'h736BECE593946EE4) begin failures++; $display("FAIL single_tk0: got %h expected 736BECE593946EE4", bus.ks_tk); end
    checks++; if (bus.rd_din !== 64'h5734F006D8D88A3E) begin failures++; $display("FAIL single_load: got %h expected 5734F006D8D88A3E", bus.rd_din); end
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL single_run_ready: got %b expected 0", bus.in_ready); end
    // inputs are free to change while running
    for (int n = 0; n < 5; n++) begin
      bus.plaintext = {$urandom, $urandom};
      bus.tweak     = {$urandom, $urandom};
      bus.key       = {$urandom, $urandom, $urandom, $urandom};
      bus.in_valid  = (n % 2 == 0);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    wait_out(5, lat);
    checks++; if (lat !== 32) begin failures++; $display("FAIL single_latency: got %0d expected 32", lat); end
    bus.out_ready = 1'b1;
    #1;
    exp = (sb_q.size() != 0) ? sb_q.pop_front() : 64'hx;
    checks++; if (bus.ciphertext !== exp) begin failures++; $display("FAIL single_ciphertext: got %h expected %h", bus.ciphertext, exp); end
    @(negedge clk);
    bus.out_ready = 1'b0;
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin failures++; $display("FAIL single_return_idle: got out_valid=%b in_ready=%b expected 0/1", bus.out_valid, bus.in_ready); end
  endtask

  task automatic test_rc_trace();
    bit ok;
    logic [3:0] a;
    logic [2:0] b;
    logic [7:0] exp_rc;
    logic [63:0] exp;
    accept_block({$urandom, $urandom}, {$urandom, $urandom},
                 {$urandom, $urandom, $urandom, $urandom}, ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL trace_accept: got %b expected 1", ok); end
    a = 4'h1;
    b = 3'h1;
    for (int k = 0; k < 32; k++) begin
      exp_rc = (k < 16) ? RC_TAB[k] : {a, 1'b0, b};
      checks++; if (bus.ks_r !== 8'(k)) begin failures++; $display("FAIL trace_ks_r: got %0d expected %0d", bus.ks_r, k); end
      checks++; if (bus.rd_rc !== exp_rc) begin failures++; $display("FAIL trace_rc[%0d]: got %h expected %h", k, bus.rd_rc, exp_rc); end
      checks++; if (bus.rd_last !== (k == 31)) begin failures++; $display("FAIL trace_last[%0d]: got %b expected %b", k, bus.rd_last, (k == 31)); end
      a = {a[0] ^ a[1], a[3:1]};
      b = {b[0] ^ b[1], b[2:1]};
      @(negedge clk);
    end
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL trace_done_valid: got %b expected 1", bus.out_valid); end
    bus.out_ready = 1'b1;
    #1;
    exp = (sb_q.size() != 0) ? sb_q.pop_front() : 64'hx;
    checks++; if (bus.ciphertext !== exp) begin failures++; $display("FAIL trace_ciphertext: got %h expected %h", bus.ciphertext, exp); end
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    bit ok;
    int lat;
    logic [63:0] exp;
    accept_block({$urandom, $urandom}, {$urandom, $urandom},
                 {$urandom, $urandom, $urandom, $urandom}, ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL bp_accept: got %b expected 1", ok); end
    wait_out(0, lat);
    checks++; if (lat !== 32) begin failures++; $display("FAIL bp_latency: got %0d expected 32", lat); end
    exp = (sb_q.size() != 0) ? sb_q[0] : 64'hx;
    for (int n = 0; n < 10; n++) begin
      bus.in_valid  = (n % 2 == 0);
      bus.plaintext = {$urandom, $urandom};
      #1;
      checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL bp_hold_valid[%0d]: got %b expected 1", n, bus.out_valid); end
      checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready[%0d]: got %b expected 0", n, bus.in_ready); end
      checks++; if (bus.ciphertext !== exp) begin failures++; $display("FAIL bp_stable[%0d]: got %h expected %h", n, bus.ciphertext, exp); end
      @(negedge clk);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    exp = (sb_q.size() != 0) ? sb_q.pop_front() : 64'hx;
    checks++; if (bus.ciphertext !== exp) begin failures++; $display("FAIL bp_ciphertext: got %h expected %h", bus.ciphertext, exp); end
    @(negedge clk);
    bus.out_ready = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL bp_release: got %b expected 0", bus.out_valid); end
  endtask

  task automatic test_reset_mid_run();
    bit ok;
    int lat;
    int seen;
    logic [63:0] exp;
    accept_block({$urandom, $urandom}, {$urandom, $urandom},
                 {$urandom, $urandom, $urandom, $urandom}, ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL mid_accept: got %b expected 1", ok); end
    repeat (17) @(negedge clk);
    checks++; if (bus.ks_r !== 8'd17) begin failures++; $display("FAIL mid_round17: got %0d expected 17", bus.ks_r); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin failures++; $display("FAIL mid_reset_hs: got in_ready=%b out_valid=%b expected 1/0", bus.in_ready, bus.out_valid); end
    checks++; if (bus.ks_r !== 8'd0 || bus.rd_rc !== 8'h11) begin failures++; $display("FAIL mid_reset_ctr: got ks_r=%h rc=%h expected 00/11", bus.ks_r, bus.rd_rc); end
    checks++; if (bus.rd_din !== 64'h0 || bus.ks_tweak !== 64'h0) begin failures++; $display("FAIL mid_reset_regs: got state=%h tweak=%h expected 0/0", bus.rd_din, bus.ks_tweak); end
    if (sb_q.size() != 0) void'(sb_q.pop_back());
    rst = 1'b0;
    seen = 0;
    for (int n = 0; n < 40; n++) begin
      if (bus.out_valid !== 1'b0) seen++;
      @(negedge clk);
    end
    checks++; if (seen !== 0) begin failures++; $display("FAIL mid_no_output: got %0d valid cycles expected 0", seen); end
    accept_block({$urandom, $urandom}, {$urandom, $urandom},
                 {$urandom, $urandom, $urandom, $urandom}, ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL mid_fresh_accept: got %b expected 1", ok); end
    wait_out(0, lat);
    checks++; if (lat !== 32) begin failures++; $display("FAIL mid_fresh_latency: got %0d expected 32", lat); end
    bus.out_ready = 1'b1;
    #1;
    exp = (sb_q.size() != 0) ? sb_q.pop_front() : 64'hx;
    checks++; if (bus.ciphertext !== exp) begin failures++; $display("FAIL mid_fresh_ciphertext: got %h expected %h", bus.ciphertext, exp); end
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    bit ok;
    int lat;
    int gap;
    logic [63:0]  p2, t2;
    logic [127:0] k2;
    logic [63:0]  exp;
    accept_block({$urandom, $urandom}, {$urandom, $urandom},
                 {$urandom, $urandom, $urandom, $urandom}, ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL b2b_accept1: got %b expected 1", ok); end
    wait_out(0, lat);
    checks++; if (lat !== 32) begin failures++; $display("FAIL b2b_latency1: got %0d expected 32", lat); end
    p2 = {$urandom, $urandom};
    t2 = {$urandom, $urandom};
    k2 = {$urandom, $urandom, $urandom, $urandom};
    bus.plaintext = p2;
    bus.tweak     = t2;
    bus.key       = k2;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    checks++; if (bus.in_ready !== B2B) begin failures++; $display("FAIL b2b_ready_in_done: got %b expected %b", bus.in_ready, B2B); end
    exp = (sb_q.size() != 0) ? sb_q.pop_front() : 64'hx;
    checks++; if (bus.ciphertext !== exp) begin failures++; $display("FAIL b2b_ciphertext1: got %h expected %h", bus.ciphertext, exp); end
    gap = -1;
    for (int n = 0; n < 4 && gap < 0; n++) begin
      if (bus.in_ready) begin
        @(posedge clk);
        sb_q.push_back(golden(p2, t2, k2));
        gap = n;
      end
      @(negedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    checks++; if (gap !== (B2B ? 0 : 1)) begin failures++; $display("FAIL b2b_gap: got %0d expected %0d", gap, (B2B ? 0 : 1)); end
    checks++; if (bus.out_valid !== 1'b0 || bus.rd_din !== p2) begin failures++; $display("FAIL b2b_loaded: got out_valid=%b state=%h expected 0/%h", bus.out_valid, bus.rd_din, p2); end
    wait_out(0, lat);
    checks++; if (lat !== 32) begin failures++; $display("FAIL b2b_latency2: got %0d expected 32", lat); end
    #1;
    exp = (sb_q.size() != 0) ? sb_q.pop_front() : 64'hx;
    checks++; if (bus.ciphertext !== exp) begin failures++; $display("FAIL b2b_ciphertext2: got %h expected %h", bus.ciphertext, exp); end
    @(negedge clk);
    bus.out_ready = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain: got %b expected 0", bus.out_valid); end
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.plaintext = '0;
    bus.tweak     = '0;
    bus.key       = '0;
    test_reset();
    test_single_block();
    test_rc_trace();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
